// File: rtl/jtag_scan_sequencer_if.sv
// jtag_scan_sequencer_if: host command/response handshake bundle for the JTAG scan sequencer
interface jtag_scan_sequencer_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_reset;
  logic               cmd_ir;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  modport master (
    output cmd_valid, cmd_reset, cmd_ir, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_reset, cmd_ir, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: command-driven JTAG master walking the TAP through IR/DR scans
module jtag_scan_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  jtag_scan_sequencer_if.slave bus,
  output logic                 tck,
  output logic                 tms,
  output logic                 tdi,
  input  logic                 tdo
);
  localparam int CW = LEN_W > 3 ? LEN_W : 3;
  localparam logic [2:0] INIT = 3'd0, READY = 3'd1, TLR = 3'd2, PRE = 3'd3;
  localparam logic [2:0] SHIFT = 3'd4, POST = 3'd5, RESP = 3'd6, ERR = 3'd7;
  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, last;
  logic               ir_q, ir_d, err_q, err_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d, rdat_q, rdat_d, sh_d;
  logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic               accept, bad_len;
  assign accept  = state_q == READY && bus.cmd_valid;
  assign bad_len = bus.cmd_len == '0 || bus.cmd_len > LEN_W'(MAX_LEN);
  assign last = (state_q == INIT || state_q == TLR) ? CW'(5)
              : state_q == PRE   ? (ir_q ? CW'(3) : CW'(2))
              : state_q == SHIFT ? CW'(len_q) - CW'(1)
              : CW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    len_d   = len_q;
    data_d  = data_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    tck_d   = 1'b0;
    case (state_q)
      READY: if (accept) begin
        ir_d    = bus.cmd_ir;
        len_d   = bus.cmd_len;
        data_d  = bus.cmd_data;
        rdat_d  = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = bus.cmd_reset ? TLR : bad_len ? ERR : PRE;
      end
      RESP: if (bus.rsp_ready) state_d = READY;
      ERR: begin
        err_d   = 1'b1;
        state_d = RESP;
      end
      default: begin
        tck_d = !tck_q;
        if (!tck_q && state_q == SHIFT) rdat_d = rdat_q | (MAX_LEN'(tdo) << cnt_q);
        if (tck_q) begin
          cnt_d = cnt_q == last ? '0 : cnt_q + 1'b1;
          if (cnt_q == last)
            state_d = state_q == INIT ? READY : state_q == PRE ? SHIFT : state_q == SHIFT ? POST : RESP;
        end
      end
    endcase
    // tms/tdi follow the bit about to be presented; unchanged while tck is high since cnt/state hold
    sh_d  = data_d >> cnt_d;
    tdi_d = state_d == SHIFT && sh_d[0];
    tms_d = (state_d == INIT || state_d == TLR) ? cnt_d != CW'(5)
          : state_d == PRE   ? (ir_d ? cnt_d < CW'(2) : cnt_d == '0)
          : state_d == SHIFT ? cnt_d == CW'(len_d) - CW'(1)
          : state_d == POST && cnt_d == '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ir_q    <= 1'b0;
      len_q   <= '0;
      data_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      len_q   <= len_d;
      data_q  <= data_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  assign tck           = tck_q;
  assign tms           = tms_q;
  assign tdi           = tdi_q;
  assign bus.cmd_ready = state_q == READY;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_data  = rdat_q;
  assign bus.rsp_err   = err_q;
endmodule
